// File: rtl/sram_responder.sv
// Single-port 128 x 32b word store answering MMU read/write pulses with byte-lane masking,
// a fixed per-operation latency and a one-cycle ack (plus err for simultaneous pulses).
module sram_responder #(
    parameter int ADDR_W    = 7,
    parameter int DATA_W    = 32,
    parameter int READ_LAT  = 2,
    parameter int WRITE_LAT = 1
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [ADDR_W-1:0]     SRAM_addr_sel,
    input  logic [DATA_W/8-1:0]   SRAM_byte_sel,
    input  logic                  read_pulse,
    input  logic                  write_pulse,
    input  logic [DATA_W-1:0]     SRAM_dat_in,
    output logic [DATA_W-1:0]     SRAM_dat_out,
    output logic                  sram_ack,
    output logic                  sram_busy,
    output logic                  sram_err
);

    localparam int LANES   = DATA_W / 8;
    localparam int DEPTH   = 2 ** ADDR_W;
    localparam int MAX_LAT = (READ_LAT > WRITE_LAT) ? READ_LAT : WRITE_LAT;
    localparam int CNT_W   = $clog2(MAX_LAT) + 1;

    typedef enum logic [1:0] {IDLE, RD_WAIT, WR_WAIT, RESP} state_t;

    state_t              state;
    logic [CNT_W-1:0]    cnt;
    logic                err_lat;
    logic [ADDR_W-1:0]   addr_q;
    logic [LANES-1:0]    sel_q;
    logic [DATA_W-1:0]   dat_q;
    logic [DATA_W-1:0]   mem [DEPTH];

    logic commit;

    function automatic logic [DATA_W-1:0] lane_mask(input logic [LANES-1:0] sel);
        logic [DATA_W-1:0] m;
        m = '0;
        for (int i = 0; i < LANES; i++) begin
            if (sel[i]) m[8*i +: 8] = 8'hFF;
        end
        return m;
    endfunction

    assign commit = (state == WR_WAIT) && (cnt == '0);

    // Control FSM and all registered outputs
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state        <= IDLE;
            cnt          <= '0;
            err_lat      <= 1'b0;
            sram_ack     <= 1'b0;
            sram_busy    <= 1'b0;
            sram_err     <= 1'b0;
            SRAM_dat_out <= '0;
        end else begin
            sram_ack <= 1'b0;
            sram_err <= 1'b0;
            case (state)
                IDLE: begin
                    if (read_pulse && write_pulse) begin
                        err_lat   <= 1'b1;
                        cnt       <= '0;
                        state     <= RD_WAIT;
                        sram_busy <= 1'b1;
                    end else if (read_pulse) begin
                        err_lat   <= 1'b0;
                        cnt       <= CNT_W'(READ_LAT - 1);
                        state     <= RD_WAIT;
                        sram_busy <= 1'b1;
                    end else if (write_pulse) begin
                        err_lat   <= 1'b0;
                        cnt       <= CNT_W'(WRITE_LAT - 1);
                        state     <= WR_WAIT;
                        sram_busy <= 1'b1;
                    end
                end
                RD_WAIT: begin
                    if (cnt == '0) begin
                        state        <= RESP;
                        sram_ack     <= 1'b1;
                        sram_err     <= err_lat;
                        SRAM_dat_out <= err_lat ? '0 : (mem[addr_q] & lane_mask(sel_q));
                    end else begin
                        cnt <= cnt - CNT_W'(1);
                    end
                end
                WR_WAIT: begin
                    if (cnt == '0) begin
                        state    <= RESP;
                        sram_ack <= 1'b1;
                    end else begin
                        cnt <= cnt - CNT_W'(1);
                    end
                end
                RESP: begin
                    state     <= IDLE;
                    sram_busy <= 1'b0;
                end
                default: state <= IDLE;
            endcase
        end
    end

    // Request capture: only an idle responder accepts a new request
    always_ff @(posedge clk) begin
        if (state == IDLE && (read_pulse || write_pulse)) begin
            addr_q <= SRAM_addr_sel;
            sel_q  <= SRAM_byte_sel;
            dat_q  <= SRAM_dat_in;
        end
    end

    // Array is never reset; an aborted write leaves the FSM in IDLE so it never commits
    always_ff @(posedge clk) begin
        if (commit) begin
            for (int i = 0; i < LANES; i++) begin
                if (sel_q[i]) mem[addr_q][8*i +: 8] <= dat_q[8*i +: 8];
            end
        end
    end

endmodule

// File: tb/tb_sram_responder.sv
// Scoreboard bench for sram_responder: a word-array reference model predicts each ack's
// cycle, err flag and read data; a negedge monitor pops and compares on every ack.
module tb_sram_responder;

    localparam int RL = 2;
    localparam int WL = 1;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [6:0]  addr = '0;
    logic [3:0]  sel = '0;
    logic        rp = 1'b0;
    logic        wp = 1'b0;
    logic [31:0] din = '0;
    logic [31:0] dout;
    logic        ack, busy, err;

    sram_responder #(.ADDR_W(7), .DATA_W(32), .READ_LAT(RL), .WRITE_LAT(WL)) dut (
        .clk(clk), .rst(rst), .SRAM_addr_sel(addr), .SRAM_byte_sel(sel),
        .read_pulse(rp), .write_pulse(wp), .SRAM_dat_in(din),
        .SRAM_dat_out(dout), .sram_ack(ack), .sram_busy(busy), .sram_err(err)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        int          at;
        logic        err;
        logic [31:0] dat;
    } exp_t;

    exp_t        sb[$];
    logic [31:0] ref_mem [128];
    logic [31:0] exp_dat = '0;
    int          n_cmp = 0;
    int          n_bad = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] req);
        n_cmp++;
        if (act !== req) begin
            n_bad++;
            $display("FAIL %s: got %h required %h (t=%0t)", nm, act, req, $time);
        end
    endtask

    function automatic logic [31:0] mask(input logic [3:0] s);
        logic [31:0] m;
        m = '0;
        for (int i = 0; i < 4; i++) if (s[i]) m[8*i +: 8] = 8'hFF;
        return m;
    endfunction

    task automatic wait_idle();
        int n;
        n = 0;
        while (busy && n < 20) begin
            @(negedge clk);
            n++;
        end
        if (n >= 20) chk("busy_timeout", 32'(busy), 32'd0);
    endtask

    // Called at a negedge with the DUT idle; returns at a negedge with the DUT idle again.
    task automatic op(input logic r, input logic w, input logic [6:0] a,
                      input logic [3:0] s, input logic [31:0] d, input logic intrude);
        exp_t e;
        int   lat;
        if (r && w) begin
            lat = 1; exp_dat = '0; e.err = 1'b1;
        end else if (r) begin
            lat = RL; exp_dat = ref_mem[a] & mask(s); e.err = 1'b0;
        end else begin
            lat = WL; e.err = 1'b0;
            ref_mem[a] = (ref_mem[a] & ~mask(s)) | (d & mask(s));
        end
        e.dat = exp_dat;
        e.at  = cyc + 1 + lat;
        sb.push_back(e);
        rp = r; wp = w; addr = a; sel = s; din = d;
        @(negedge clk);
        rp = 1'b0; wp = 1'b0; addr = 7'($urandom); din = $urandom; sel = 4'($urandom);
        if (intrude) begin
            if ($urandom_range(0, 1) == 1) rp = 1'b1; else wp = 1'b1;
            @(negedge clk);
            rp = 1'b0; wp = 1'b0;
        end
        wait_idle();
    endtask

    always @(negedge clk) begin
        exp_t e;
        if (err && !ack) chk("err_without_ack", 32'(err), 32'd0);
        if (ack) begin
            if (sb.size() == 0) begin
                chk("unexpected_ack", 32'(ack), 32'd0);
            end else begin
                e = sb.pop_front();
                chk("ack_cycle", 32'(cyc), 32'(e.at));
                chk("err_flag", 32'(err), 32'(e.err));
                chk("dat_out", dout, e.dat);
            end
        end
    end

    initial begin
        #500000;
        $display("FAIL global_timeout: got still running required finished");
        $fatal(1, "timeout");
    end

    initial begin
        logic [31:0] d;
        logic [3:0]  s;
        int          k;
        repeat (2) @(negedge clk);
        chk("rst_ack", 32'(ack), 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_err", 32'(err), 32'd0);
        chk("rst_dout", dout, 32'd0);
        rst = 1'b0;
        @(negedge clk);

        for (int a = 0; a < 128; a++) op(1'b0, 1'b1, 7'(a), 4'hF, $urandom, 1'b0);

        op(1'b0, 1'b1, 7'd5, 4'hF, 32'hDEADBEEF, 1'b0);
        op(1'b1, 1'b0, 7'd5, 4'hF, 32'h0, 1'b0);
        chk("t1_read", dout, 32'hDEADBEEF);

        op(1'b0, 1'b1, 7'd9, 4'hF, 32'h11223344, 1'b0);
        op(1'b0, 1'b1, 7'd9, 4'b0101, 32'hAABBCCDD, 1'b0);
        op(1'b1, 1'b0, 7'd9, 4'hF, 32'h0, 1'b0);
        chk("t2_merge", dout, 32'h11BB33DD);

        op(1'b1, 1'b0, 7'd9, 4'b1000, 32'h0, 1'b0);
        chk("t3_lane", dout, 32'h11000000);

        op(1'b1, 1'b1, 7'd9, 4'hF, 32'hFFFFFFFF, 1'b0);
        chk("t4_err_dout", dout, 32'h0);
        op(1'b1, 1'b0, 7'd9, 4'hF, 32'h0, 1'b0);
        chk("t4_mem_kept", dout, 32'h11BB33DD);

        op(1'b1, 1'b0, 7'd5, 4'hF, 32'h0, 1'b1);
        op(1'b0, 1'b1, 7'd9, 4'h0, 32'h55555555, 1'b1);
        op(1'b1, 1'b0, 7'd9, 4'hF, 32'h0, 1'b0);
        chk("t5_sel0_write", dout, 32'h11BB33DD);
        op(1'b1, 1'b0, 7'd9, 4'h0, 32'h0, 1'b0);
        chk("t5_sel0_read", dout, 32'h0);

        // Abort a write while it is in flight
        rp = 1'b0; wp = 1'b1; addr = 7'd9; sel = 4'hF; din = 32'h99999999;
        @(negedge clk);
        wp = 1'b0;
        #2 rst = 1'b1;
        #1;
        chk("abort_ack", 32'(ack), 32'd0);
        chk("abort_busy", 32'(busy), 32'd0);
        chk("abort_dout", dout, 32'd0);
        @(negedge clk);
        rst = 1'b0;
        exp_dat = '0;
        @(negedge clk);
        op(1'b1, 1'b0, 7'd9, 4'hF, 32'h0, 1'b0);
        chk("t6_old_data", dout, 32'h11BB33DD);

        op(1'b0, 1'b1, 7'd127, 4'hF, 32'hCAFEF00D, 1'b0);
        op(1'b0, 1'b1, 7'd0, 4'hF, 32'h0BADC0DE, 1'b0);
        op(1'b1, 1'b0, 7'd127, 4'hF, 32'h0, 1'b0);
        chk("t6_addr127", dout, 32'hCAFEF00D);
        op(1'b1, 1'b0, 7'd0, 4'hF, 32'h0, 1'b0);
        chk("t6_addr0", dout, 32'h0BADC0DE);

        for (int i = 0; i < 300; i++) begin
            k = $urandom_range(0, 9);
            d = $urandom;
            s = 4'($urandom);
            op(k == 0 || k <= 4, k == 0 || k >= 5, 7'($urandom), s, d,
               1'($urandom_range(0, 3) == 0));
        end

        repeat (5) @(negedge clk);
        chk("scoreboard_drained", 32'(sb.size()), 32'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
